// File: rtl/huffman_symbol_counter.sv
// Histogram front-end of the Huffman datapath: counts symbols 1..6 over one
// frame, then packs the non-zero counts into slots O1..O6 for the sorter.
module huffman_symbol_counter #(
   parameter int unsigned N_PIX = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       gray_valid,
   input  logic [7:0] gray_data,
   output logic [7:0] CNT1,
   output logic [7:0] CNT2,
   output logic [7:0] CNT3,
   output logic [7:0] CNT4,
   output logic [7:0] CNT5,
   output logic [7:0] CNT6,
   output logic [7:0] O1,
   output logic [7:0] O2,
   output logic [7:0] O3,
   output logic [7:0] O4,
   output logic [7:0] O5,
   output logic [7:0] O6,
   output logic [2:0] sym1,
   output logic [2:0] sym2,
   output logic [2:0] sym3,
   output logic [2:0] sym4,
   output logic [2:0] sym5,
   output logic [2:0] sym6,
   output logic [2:0] num,
   output logic       bad_sym,
   output logic       CNT_valid
);

   typedef enum logic [1:0] {
      COUNT = 2'd0,
      PACK  = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(N_PIX - 1);
   localparam logic [2:0] LAST_SYM = 3'd5;

   state_t     state;
   state_t     state_nxt;

   logic [7:0] cnt [6];
   logic [7:0] slot [6];
   logic [2:0] owner [6];
   logic [7:0] pix_cnt;
   logic [2:0] wp;
   logic [2:0] idx;

   logic       accept;
   logic       legal;
   logic [2:0] sel;
   logic       frame_end;

   assign accept    = (state == COUNT) && gray_valid;
   assign legal     = (gray_data >= 8'd1) && (gray_data <= 8'd6);
   assign sel       = gray_data[2:0] - 3'd1;
   assign frame_end = accept && (pix_cnt == LAST_IDX);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= COUNT;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: combinational block assigns every output first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         COUNT:   if (frame_end) state_nxt = PACK;
         PACK:    if (idx == LAST_SYM) state_nxt = DONE;
         DONE:    state_nxt = DONE;
         default: state_nxt = COUNT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the small count/slot arrays are flops, not RAM, so they are cleared like any register.
         for (int k = 0; k < 6; k++) begin
            cnt[k]   <= 8'd0;
            slot[k]  <= 8'd0;
            owner[k] <= 3'd0;
         end
         pix_cnt   <= 8'd0;
         wp        <= 3'd0;
         idx       <= 3'd0;
         num       <= 3'd0;
         bad_sym   <= 1'b0;
         CNT_valid <= 1'b0;
      end else begin
         if (accept) begin
            pix_cnt <= pix_cnt + 8'd1;
            if (legal) begin
               if (cnt[sel] != 8'hFF) cnt[sel] <= cnt[sel] + 8'd1;
            end else begin
               bad_sym <= 1'b1;
            end
         end

         // One symbol per PACK cycle; zero counts are skipped so slots stay contiguous.
         if (state == PACK) begin
            idx <= idx + 3'd1;
            if (cnt[idx] != 8'd0) begin
               slot[wp]  <= cnt[idx];
               owner[wp] <= idx + 3'd1;
               wp        <= wp + 3'd1;
               num       <= num + 3'd1;
            end
         end

         CNT_valid <= (state == DONE);
      end
   end

   assign CNT1 = cnt[0];
   assign CNT2 = cnt[1];
   assign CNT3 = cnt[2];
   assign CNT4 = cnt[3];
   assign CNT5 = cnt[4];
   assign CNT6 = cnt[5];

   assign O1 = slot[0];
   assign O2 = slot[1];
   assign O3 = slot[2];
   assign O4 = slot[3];
   assign O5 = slot[4];
   assign O6 = slot[5];

   assign sym1 = owner[0];
   assign sym2 = owner[1];
   assign sym3 = owner[2];
   assign sym4 = owner[3];
   assign sym5 = owner[4];
   assign sym6 = owner[5];

endmodule

// File: tb/tb_huffman_symbol_counter.sv
// Directed bench for huffman_symbol_counter: frame histograms, packing,
// frame-end timing, resets and the N_PIX=1 corner on a second instance.
module tb_huffman_symbol_counter;

   logic       clk;
   logic       reset;
   logic       gray_valid;
   logic [7:0] gray_data;
   logic [7:0] CNT1, CNT2, CNT3, CNT4, CNT5, CNT6;
   logic [7:0] O1, O2, O3, O4, O5, O6;
   logic [2:0] sym1, sym2, sym3, sym4, sym5, sym6;
   logic [2:0] num;
   logic       bad_sym;
   logic       CNT_valid;

   logic       gv1;
   logic [7:0] gd1;
   logic [7:0] c1_1, c1_2, c1_3, c1_4, c1_5, c1_6;
   logic [7:0] o1_1, o1_2, o1_3, o1_4, o1_5, o1_6;
   logic [2:0] s1_1, s1_2, s1_3, s1_4, s1_5, s1_6;
   logic [2:0] num1;
   logic       bad1;
   logic       valid1;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   logic [0:5][7:0] cnt_v;
   logic [0:5][7:0] o_v;
   logic [0:5][2:0] sym_v;

   assign cnt_v = {CNT1, CNT2, CNT3, CNT4, CNT5, CNT6};
   assign o_v   = {O1, O2, O3, O4, O5, O6};
   assign sym_v = {sym1, sym2, sym3, sym4, sym5, sym6};

   huffman_symbol_counter #(.N_PIX(100)) dut (
      .clk(clk), .reset(reset), .gray_valid(gray_valid), .gray_data(gray_data),
      .CNT1(CNT1), .CNT2(CNT2), .CNT3(CNT3), .CNT4(CNT4), .CNT5(CNT5), .CNT6(CNT6),
      .O1(O1), .O2(O2), .O3(O3), .O4(O4), .O5(O5), .O6(O6),
      .sym1(sym1), .sym2(sym2), .sym3(sym3), .sym4(sym4), .sym5(sym5), .sym6(sym6),
      .num(num), .bad_sym(bad_sym), .CNT_valid(CNT_valid)
   );

   huffman_symbol_counter #(.N_PIX(1)) dut_one (
      .clk(clk), .reset(reset), .gray_valid(gv1), .gray_data(gd1),
      .CNT1(c1_1), .CNT2(c1_2), .CNT3(c1_3), .CNT4(c1_4), .CNT5(c1_5), .CNT6(c1_6),
      .O1(o1_1), .O2(o1_2), .O3(o1_3), .O4(o1_4), .O5(o1_5), .O6(o1_6),
      .sym1(s1_1), .sym2(s1_2), .sym3(s1_3), .sym4(s1_4), .sym5(s1_5), .sym6(s1_6),
      .num(num1), .bad_sym(bad1), .CNT_valid(valid1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_frame(input string tag,
                              input logic [0:5][7:0] e_cnt,
                              input logic [0:5][7:0] e_o,
                              input logic [0:5][2:0] e_sym,
                              input logic [2:0]      e_num,
                              input logic            e_bad);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("%s CNT%0d", tag, k + 1), cnt_v[k], e_cnt[k]);
         check($sformatf("%s O%0d", tag, k + 1), o_v[k], e_o[k]);
         check($sformatf("%s sym%0d", tag, k + 1), sym_v[k], e_sym[k]);
      end
      check({tag, " num"}, num, e_num);
      check({tag, " bad_sym"}, bad_sym, e_bad);
   endtask

   task automatic send(input logic [7:0] d);
      @(negedge clk);
      gray_valid = 1'b1;
      gray_data  = d;
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      gray_valid = 1'b0;
      @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset      = 1'b1;
      gray_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Called right after edge E0; CNT_valid must be low after E1..E6 and high after E7.
   task automatic check_frame_end(input string tag);
      @(negedge clk);
      gray_valid = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("%s CNT_valid E%0d", tag, k), CNT_valid, (k == 7) ? 1 : 0);
      end
   endtask

   localparam logic [0:5][7:0] ZERO8 = '0;
   localparam logic [0:5][2:0] ZERO3 = '0;

   initial begin
      logic [7:0] pix [100];
      int         rem [1:6];
      int         s;
      logic [7:0] d;

      reset      = 1'b1;
      gray_valid = 1'b0;
      gray_data  = 8'd0;
      gv1        = 1'b0;
      gd1        = 8'd0;

      // Reset state
      @(posedge clk);
      @(posedge clk);
      #1;
      check_frame("reset", ZERO8, ZERO8, ZERO3, 3'd0, 1'b0);
      check("reset CNT_valid", CNT_valid, 0);
      @(negedge clk);
      reset = 1'b0;

      // Single symbol: 100 x symbol 3, no gaps
      send(8'd3);
      #1;
      check("single CNT3 latency", CNT3, 1);
      for (int i = 1; i < 100; i++) send(8'd3);
      check_frame_end("single");
      check_frame("single", {8'd0, 8'd0, 8'd100, 8'd0, 8'd0, 8'd0},
                  {8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                  {3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 3'd1, 1'b0);

      // Sparse histogram {10,0,25,0,40,25} with random gaps
      do_reset();
      for (int i = 0; i < 100; i++) begin
         if ($urandom_range(0, 2) == 0) idle();
         d = (i < 10) ? 8'd1 : (i < 35) ? 8'd3 : (i < 75) ? 8'd5 : 8'd6;
         send(d);
      end
      check_frame_end("sparse");
      check_frame("sparse", {8'd10, 8'd0, 8'd25, 8'd0, 8'd40, 8'd25},
                  {8'd10, 8'd25, 8'd40, 8'd25, 8'd0, 8'd0},
                  {3'd1, 3'd3, 3'd5, 3'd6, 3'd0, 3'd0}, 3'd4, 1'b0);

      // Out-of-range: five 0s, three 9s, rest 16,16,15,15,15,15
      do_reset();
      rem[1] = 16; rem[2] = 16; rem[3] = 15; rem[4] = 15; rem[5] = 15; rem[6] = 15;
      s = 1;
      for (int i = 0; i < 100; i++) begin
         if (i % 20 == 0) pix[i] = 8'd0;
         else if ((i % 20 == 10) && (i < 60)) pix[i] = 8'd9;
         else begin
            while (rem[s] == 0) s = (s % 6) + 1;
            pix[i] = 8'(s);
            rem[s]--;
            s = (s % 6) + 1;
         end
      end
      send(pix[0]);
      #1;
      check("bad first bad_sym", bad_sym, 1);
      for (int i = 1; i < 100; i++) send(pix[i]);
      check_frame_end("bad");
      check_frame("bad", {8'd16, 8'd16, 8'd15, 8'd15, 8'd15, 8'd15},
                  {8'd16, 8'd16, 8'd15, 8'd15, 8'd15, 8'd15},
                  {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6}, 3'd6, 1'b1);

      // Reset mid-frame after 50 pixels, with a pixel on the reset edge
      do_reset();
      for (int i = 0; i < 50; i++) send(8'd4);
      @(negedge clk);
      reset      = 1'b1;
      gray_valid = 1'b1;
      gray_data  = 8'd1;
      @(posedge clk);
      #1;
      check_frame("rst_count", ZERO8, ZERO8, ZERO3, 3'd0, 1'b0);
      check("rst_count CNT_valid", CNT_valid, 0);
      @(negedge clk);
      reset      = 1'b0;
      gray_valid = 1'b0;

      // Reset during PACK, after symbol 2 has already been packed
      for (int i = 0; i < 100; i++) send(8'd2);
      @(negedge clk);
      gray_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("pack O1 before reset", O1, 100);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_frame("rst_pack", ZERO8, ZERO8, ZERO3, 3'd0, 1'b0);
      check("rst_pack CNT_valid", CNT_valid, 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 100; i++) send(8'd6);
      check_frame_end("after_rst");
      check_frame("after_rst", {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd100},
                  {8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                  {3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 3'd1, 1'b0);

      // Post-done stability: pixels are ignored in DONE
      for (int i = 0; i < 20; i++) send(8'd1);
      @(negedge clk);
      gray_valid = 1'b0;
      check_frame("post_done", {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd100},
                  {8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                  {3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 3'd1, 1'b0);
      check("post_done CNT_valid", CNT_valid, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("done_rst CNT_valid", CNT_valid, 0);
      check("done_rst num", num, 0);
      check("done_rst CNT6", CNT6, 0);
      @(negedge clk);
      reset = 1'b0;

      // Parameter corner: N_PIX=1, one pixel of symbol 2
      @(negedge clk);
      gv1 = 1'b1;
      gd1 = 8'd2;
      @(posedge clk);
      #1;
      check("one CNT2", c1_2, 1);
      @(negedge clk);
      gv1 = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("one CNT_valid E%0d", k), valid1, (k == 7) ? 1 : 0);
      end
      check("one num", num1, 1);
      check("one O1", o1_1, 1);
      check("one sym1", s1_1, 2);
      check("one O2", o1_2, 0);
      check("one CNT1", c1_1, 0);
      check("one bad_sym", bad1, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
